// File: rtl/iot_mon_pkg.sv
// Shared types and width helpers for the IoT multi-channel device monitor.
package iot_mon_pkg;

   typedef enum logic {
      NORMAL = 1'b0,
      ALARM  = 1'b1
   } alarm_state_t;

   // Width of the system total: per-channel width plus headroom for N_CH addends plus a sign guard.
   function automatic int tw_calc(input int n_ch, input int width);
      return width + $clog2(n_ch) + 1;
   endfunction

   function automatic int sel_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/iot_mon_if.sv
// Event/status bus between the device-event decoder, the monitor and the CSR block.
// Peak-tracking signals exist only when IOT_MON_PEAK_EN is defined.
interface iot_mon_if
   import iot_mon_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8
) ();

   localparam int TW = tw_calc(N_CH, WIDTH);
   localparam int SW = sel_w(N_CH);

   logic [N_CH-1:0]  change;
   logic [N_CH-1:0]  on_off;
   logic [N_CH-1:0]  clr;
   logic [SW-1:0]    rd_sel;
   logic [WIDTH-1:0] rd_count;
   logic [TW-1:0]    total;
   logic             alarm;
   logic [N_CH-1:0]  sat_evt;

`ifdef IOT_MON_PEAK_EN
   logic             peak_clr;
   logic [TW-1:0]    peak;

   modport master (
      output change, on_off, clr, rd_sel, peak_clr,
      input  rd_count, total, alarm, sat_evt, peak
   );

   modport slave (
      input  change, on_off, clr, rd_sel, peak_clr,
      output rd_count, total, alarm, sat_evt, peak
   );
`else
   modport master (
      output change, on_off, clr, rd_sel,
      input  rd_count, total, alarm, sat_evt
   );

   modport slave (
      input  change, on_off, clr, rd_sel,
      output rd_count, total, alarm, sat_evt
   );
`endif

endinterface

// File: rtl/iot_chan_counter.sv
// One device-group counter: clear/step with wrap or saturation, reporting the applied signed delta.
module iot_chan_counter #(
   parameter int WIDTH = 8,
   parameter int SAT   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    change,
   input  logic                    on_off,
   input  logic                    clr,
   output logic [WIDTH-1:0]        count,
   output logic signed [WIDTH:0]   delta,
   output logic                    sat_evt
);

   localparam logic [WIDTH-1:0] MAX_CNT = '1;

   logic [WIDTH-1:0] r_count;
   logic             r_sat_evt;
   logic [WIDTH-1:0] w_next;
   logic             w_sat;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_count;
      w_sat  = 1'b0;
      if (clr) begin
         w_next = '0;
      end else if (change) begin
         if (on_off) begin
            if (SAT != 0 && r_count == MAX_CNT) w_sat  = 1'b1;
            else                                w_next = r_count + 1'b1;
         end else begin
            if (SAT != 0 && r_count == '0)      w_sat  = 1'b1;
            else                                w_next = r_count - 1'b1;
         end
      end
   end

   // Applied change, so the wrap jump and a clear of a full counter are both carried exactly.
   assign delta = $signed({1'b0, w_next}) - $signed({1'b0, r_count});

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_sat_evt <= 1'b0;
      end else begin
         r_count   <= w_next;
         r_sat_evt <= w_sat;
      end
   end

   assign count   = r_count;
   assign sat_evt = r_sat_evt;

endmodule

// File: rtl/iot_multi_monitor.sv
// N-channel active-device monitor: per-group counters, running total, hysteretic alarm.
// Optional peak-total register is built when IOT_MON_PEAK_EN is defined.
module iot_multi_monitor
   import iot_mon_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int WIDTH     = 8,
   parameter int SAT       = 0,
   parameter int HI_THRESH = 512,
   parameter int LO_THRESH = 384
) (
   input  logic  clk,
   input  logic  rst,
   iot_mon_if.slave bus
);

   localparam int TW = tw_calc(N_CH, WIDTH);
   localparam int SW = sel_w(N_CH);
   localparam logic [TW-1:0] HI_T = TW'(HI_THRESH);
   localparam logic [TW-1:0] LO_T = TW'(LO_THRESH);

   logic [WIDTH-1:0]        w_count [N_CH];
   logic signed [WIDTH:0]   w_delta [N_CH];
   logic [N_CH-1:0]         w_sat_evt;
   logic signed [TW-1:0]    w_delta_sum;
   logic [WIDTH-1:0]        w_rd_tbl [2**SW];

   logic [TW-1:0]           r_total;
   alarm_state_t            r_state;
   logic                    r_alarm;

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      iot_chan_counter #(
         .WIDTH (WIDTH),
         .SAT   (SAT)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .change  (bus.change[g]),
         .on_off  (bus.on_off[g]),
         .clr     (bus.clr[g]),
         .count   (w_count[g]),
         .delta   (w_delta[g]),
         .sat_evt (w_sat_evt[g])
      );
   end

   // TW holds N_CH * (2^WIDTH-1) in either sign, so the signed sum cannot overflow.
   always_comb begin
      w_delta_sum = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_delta_sum = w_delta_sum + TW'(w_delta[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_total <= '0;
      else     r_total <= r_total + $unsigned(w_delta_sum);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= NORMAL;
         r_alarm <= 1'b0;
      end else begin
         case (r_state)
            NORMAL: if (r_total >= HI_T) begin
               r_state <= ALARM;
               r_alarm <= 1'b1;
            end
            ALARM: if (r_total <= LO_T) begin
               r_state <= NORMAL;
               r_alarm <= 1'b0;
            end
            default: begin
               r_state <= NORMAL;
               r_alarm <= 1'b0;
            end
         endcase
      end
   end

   // Zero-padded lookup so an out-of-range select reads 0 without a compare.
   for (genvar r = 0; r < 2**SW; r++) begin : g_rd
      if (r < N_CH) begin : g_hit
         assign w_rd_tbl[r] = w_count[r];
      end else begin : g_pad
         assign w_rd_tbl[r] = '0;
      end
   end

   assign bus.rd_count = w_rd_tbl[bus.rd_sel];
   assign bus.total    = r_total;
   assign bus.alarm    = r_alarm;
   assign bus.sat_evt  = w_sat_evt;

`ifdef IOT_MON_PEAK_EN
   logic [TW-1:0] r_peak;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_peak <= '0;
      else if (bus.peak_clr)      r_peak <= r_total;
      else if (r_total > r_peak)  r_peak <= r_total;
   end

   assign bus.peak = r_peak;
`else
`endif

endmodule

// File: tb/tb_iot_multi_monitor.sv
// Directed-vector bench: one SAT=0 and one SAT=1 monitor, hand-computed expectations.
module tb_iot_multi_monitor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [7:0] v;

   always #5 clk = ~clk;

   iot_mon_if #(.N_CH(4), .WIDTH(8)) bus_a ();
   iot_mon_if #(.N_CH(4), .WIDTH(8)) bus_b ();

   iot_multi_monitor #(
      .N_CH(4), .WIDTH(8), .SAT(0), .HI_THRESH(512), .LO_THRESH(384)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   iot_multi_monitor #(
      .N_CH(4), .WIDTH(8), .SAT(1), .HI_THRESH(512), .LO_THRESH(384)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [3:0] chg, input logic [3:0] on, input logic [3:0] cl);
      bus_a.change = chg;
      bus_a.on_off = on;
      bus_a.clr    = cl;
      tick();
      bus_a.change = '0;
      bus_a.on_off = '0;
      bus_a.clr    = '0;
   endtask

   task automatic drive_b(input logic [3:0] chg, input logic [3:0] on, input logic [3:0] cl);
      bus_b.change = chg;
      bus_b.on_off = on;
      bus_b.clr    = cl;
      tick();
      bus_b.change = '0;
      bus_b.on_off = '0;
      bus_b.clr    = '0;
   endtask

   task automatic run_a(input logic [3:0] chg, input logic [3:0] on, input int n);
      repeat (n) drive_a(chg, on, 4'b0000);
   endtask

   task automatic run_b(input logic [3:0] chg, input logic [3:0] on, input int n);
      repeat (n) drive_b(chg, on, 4'b0000);
   endtask

   task automatic rd_a(input int ch, output logic [7:0] val);
      bus_a.rd_sel = 2'(ch);
      #1;
      val = bus_a.rd_count;
   endtask

   task automatic rd_b(input int ch, output logic [7:0] val);
      bus_b.rd_sel = 2'(ch);
      #1;
      val = bus_b.rd_count;
   endtask

   initial begin
      bus_a.change = '0; bus_a.on_off = '0; bus_a.clr = '0; bus_a.rd_sel = '0;
      bus_b.change = '0; bus_b.on_off = '0; bus_b.clr = '0; bus_b.rd_sel = '0;
`ifdef IOT_MON_PEAK_EN
      bus_a.peak_clr = 1'b0;
      bus_b.peak_clr = 1'b0;
`endif

      // Reset state
      #1 rst = 1'b1;
      #1;
      check("rst_total_a", 32'(bus_a.total), 0);
      check("rst_alarm_a", 32'(bus_a.alarm), 0);
      check("rst_sat_b", 32'(bus_b.sat_evt), 0);
      rd_a(0, v); check("rst_cnt_a0", 32'(v), 0);
      #10 rst = 1'b0;
      tick();

      // Basic increments on ch0
      run_a(4'b0001, 4'b0001, 3);
      rd_a(0, v); check("inc_cnt_a0", 32'(v), 3);
      check("inc_total", 32'(bus_a.total), 3);
      check("inc_alarm", 32'(bus_a.alarm), 0);

      // Wrap on ch1
      drive_a(4'b0010, 4'b0000, 4'b0000);
      rd_a(1, v); check("wrap_dn_cnt", 32'(v), 255);
      check("wrap_dn_total", 32'(bus_a.total), 258);
      check("wrap_no_sat", 32'(bus_a.sat_evt), 0);
      drive_a(4'b0010, 4'b0010, 4'b0000);
      rd_a(1, v); check("wrap_up_cnt", 32'(v), 0);
      check("wrap_up_total", 32'(bus_a.total), 3);

      // Simultaneous events: +1, -1, clr(10), +1 -> -9
      run_a(4'b0010, 4'b0010, 5);
      run_a(4'b0100, 4'b0100, 10);
      check("simul_pre_total", 32'(bus_a.total), 18);
      drive_a(4'b1011, 4'b1001, 4'b0100);
      check("simul_total", 32'(bus_a.total), 9);
      rd_a(1, v); check("simul_cnt1", 32'(v), 4);
      rd_a(2, v); check("simul_cnt2", 32'(v), 0);
      rd_a(3, v); check("simul_cnt3", 32'(v), 1);

      // Hysteresis
      drive_a(4'b0000, 4'b0000, 4'b1111);
      check("clr_all_total", 32'(bus_a.total), 0);
      run_a(4'b1111, 4'b1111, 127);
      drive_a(4'b0111, 4'b0111, 4'b0000);
      check("hys_511_total", 32'(bus_a.total), 511);
      tick();
      check("hys_511_alarm", 32'(bus_a.alarm), 0);
      drive_a(4'b1000, 4'b1000, 4'b0000);
      check("hys_512_total", 32'(bus_a.total), 512);
      check("hys_512_lag", 32'(bus_a.alarm), 0);
      tick();
      check("hys_512_alarm", 32'(bus_a.alarm), 1);
      run_a(4'b1111, 4'b0000, 28);
      check("hys_400_total", 32'(bus_a.total), 400);
      check("hys_400_alarm", 32'(bus_a.alarm), 1);
      run_a(4'b1111, 4'b0000, 3);
      tick();
      check("hys_388_alarm", 32'(bus_a.alarm), 1);
      drive_a(4'b1111, 4'b0000, 4'b0000);
      check("hys_384_total", 32'(bus_a.total), 384);
      check("hys_384_lag", 32'(bus_a.alarm), 1);
      tick();
      check("hys_384_alarm", 32'(bus_a.alarm), 0);

      // Saturation on the SAT=1 instance
      run_b(4'b0100, 4'b0100, 255);
      check("sat_pre_total", 32'(bus_b.total), 255);
      drive_b(4'b0100, 4'b0100, 4'b0000);
      rd_b(2, v); check("sat_hi_cnt", 32'(v), 255);
      check("sat_hi_total", 32'(bus_b.total), 255);
      check("sat_hi_evt", 32'(bus_b.sat_evt), 32'h4);
      tick();
      check("sat_evt_clear", 32'(bus_b.sat_evt), 0);
      drive_b(4'b0001, 4'b0000, 4'b0000);
      rd_b(0, v); check("sat_lo_cnt", 32'(v), 0);
      check("sat_lo_evt", 32'(bus_b.sat_evt), 32'h1);
      check("sat_lo_total", 32'(bus_b.total), 255);

      // Asynchronous reset mid-operation with alarm raised
      run_a(4'b1111, 4'b1111, 32);
      tick();
      check("pre_rst_alarm", 32'(bus_a.alarm), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_total", 32'(bus_a.total), 0);
      check("arst_alarm", 32'(bus_a.alarm), 0);
      check("arst_total_b", 32'(bus_b.total), 0);
      rd_a(0, v); check("arst_cnt_a0", 32'(v), 0);
`ifdef IOT_MON_PEAK_EN
      check("arst_peak", 32'(bus_a.peak), 0);
`endif
      #2 rst = 1'b0;
      tick();

`ifdef IOT_MON_PEAK_EN
      run_a(4'b1111, 4'b1111, 150);
      check("peak_total_600", 32'(bus_a.total), 600);
      tick();
      check("peak_600", 32'(bus_a.peak), 600);
      run_a(4'b1111, 4'b0000, 10);
      tick();
      check("peak_hold", 32'(bus_a.peak), 600);
      bus_a.peak_clr = 1'b1;
      tick();
      bus_a.peak_clr = 1'b0;
      check("peak_clr", 32'(bus_a.peak), 560);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
